hazard_unit: RTL and testbench

- Pipeline hazard controller in the ID stage. It is the producer of the `clearcontrol` input that the ID control decoder consumes.
- It detects load-use data hazards and freezes the pipeline while data memory is busy.
- It squashes wrong-path instructions after a taken branch or jump, and holds a pending flush across freezes.
- It drives PC/IF-ID write enables, the ID/EX bubble request, and the IF/ID flush.

---
 rtl/hazard_unit.sv | 116 +++++++++++
 tb/tb_hazard_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// ID-stage hazard controller: load-use stall, memory-busy freeze and branch flush (held across freezes).
// Define HAZARD_PERF_EN to add the stall_cnt / flush_cnt performance counters.
module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OPCODE_WIDTH   = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [OPCODE_WIDTH-1:0]   id_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      idex_memread,
    input  logic [REG_ADDR_WIDTH-1:0] idex_rd,
    input  logic                      pcsrc,
    input  logic                      mem_busy,
    output logic                      pcwrite,
    output logic                      ifidwrite,
    output logic                      clearcontrol,
    output logic                      ifidflush,
    output logic                      pipe_hold
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               flush_cnt
`endif
);

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] HOLD       = 2'd1;
    localparam logic [1:0] FLUSH_PEND = 2'd2;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       load_use;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        if (id_opcode[1:0] == 2'b11) begin
            case (id_opcode[6:2])
                5'b01100, 5'b01000, 5'b11000: begin
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                end
                5'b11001, 5'b00000, 5'b00100: uses_rs1 = 1'b1;
                default: ;
            endcase
        end
    end

    assign load_use = idex_memread && (idex_rd != '0) &&
                      ((uses_rs1 && (idex_rd == id_rs1)) || (uses_rs2 && (idex_rd == id_rs2)));

    always_comb begin
        pcwrite      = 1'b1;
        ifidwrite    = 1'b1;
        clearcontrol = 1'b0;
        ifidflush    = 1'b0;
        pipe_hold    = 1'b0;
        state_next   = state_reg;
        if (!rst) begin
            pcwrite      = 1'b0;
            ifidwrite    = 1'b0;
            clearcontrol = 1'b1;
        end else if (mem_busy) begin
            pcwrite   = 1'b0;
            ifidwrite = 1'b0;
            pipe_hold = 1'b1;
            // A pending flush already owns the next release; later pcsrc is ignored.
            if (state_reg != FLUSH_PEND)
                state_next = pcsrc ? FLUSH_PEND : HOLD;
        end else if ((state_reg == FLUSH_PEND) || pcsrc) begin
            ifidflush    = 1'b1;
            clearcontrol = 1'b1;
            state_next   = RUN;
        end else if (load_use) begin
            pcwrite      = 1'b0;
            ifidwrite    = 1'b0;
            clearcontrol = 1'b1;
            state_next   = RUN;
        end else begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= RUN;
        else
            state_reg <= state_next;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // A stall cycle is either a freeze or a load-use bubble (PC held while ID/EX is cleared).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (pipe_hold || (clearcontrol && !pcwrite))
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (ifidflush)
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed scenarios plus random traffic against a pending-flush model.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       idex_memread = 1'b0;
    logic [4:0] idex_rd = '0;
    logic       pcsrc = 1'b0;
    logic       mem_busy = 1'b0;
    logic       pcwrite, ifidwrite, clearcontrol, ifidflush, pipe_hold;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    hazard_unit #(.REG_ADDR_WIDTH(5), .OPCODE_WIDTH(7)) dut (
        .clk(clk), .rst(rst),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .pcsrc(pcsrc), .mem_busy(mem_busy),
        .pcwrite(pcwrite), .ifidwrite(ifidwrite), .clearcontrol(clearcontrol),
        .ifidflush(ifidflush), .pipe_hold(pipe_hold)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          pw, iw, cc, fl, ph;
        bit [31:0]   sc, fc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          owe_flush = 0;
    bit [31:0]   m_stall = 0;
    bit [31:0]   m_flush = 0;

    // Register-source usage per instruction class (RV32I base opcodes).
    function automatic void src_use(input logic [6:0] op, output bit r1, output bit r2);
        r1 = 0;
        r2 = 0;
        if (op[1:0] == 2'b11) begin
            if (op[6:2] inside {5'b01100, 5'b11001, 5'b00000, 5'b00100, 5'b01000, 5'b11000}) r1 = 1;
            if (op[6:2] inside {5'b01100, 5'b01000, 5'b11000}) r2 = 1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one cycle of inputs, predicts the response and queues it.
    task automatic step(input string tag, input bit r, input logic [6:0] op, input logic [4:0] s1,
                        input logic [4:0] s2, input bit mr, input logic [4:0] rd,
                        input bit br, input bit busy, input bit wrap = 0);
        exp_t e;
        bit   r1, r2, lu, stall, flush;
        @(posedge clk);
        #1;
        if (wrap) begin
`ifdef HAZARD_PERF_EN
            force dut.stall_cnt_reg = 32'hFFFF_FFFF;
            #1;
            release dut.stall_cnt_reg;
            m_stall = 32'hFFFF_FFFF;
`endif
        end
        rst = r; id_opcode = op; id_rs1 = s1; id_rs2 = s2;
        idex_memread = mr; idex_rd = rd; pcsrc = br; mem_busy = busy;
        e.tag = tag;
        src_use(op, r1, r2);
        lu = mr && rd != 0 && ((r1 && rd == s1) || (r2 && rd == s2));
        if (!r) begin
            owe_flush = 0; m_stall = 0; m_flush = 0;
            e.sc = 0; e.fc = 0;
            {e.pw, e.iw, e.cc, e.fl, e.ph} = 5'b00100;
        end else begin
            e.sc = m_stall; e.fc = m_flush;
            stall = 0; flush = 0;
            if (busy) begin
                {e.pw, e.iw, e.cc, e.fl, e.ph} = 5'b00001;
                if (br) owe_flush = 1;
                stall = 1;
            end else if (owe_flush || br) begin
                {e.pw, e.iw, e.cc, e.fl, e.ph} = 5'b11110;
                owe_flush = 0;
                flush = 1;
            end else if (lu) begin
                {e.pw, e.iw, e.cc, e.fl, e.ph} = 5'b00100;
                stall = 1;
            end else begin
                {e.pw, e.iw, e.cc, e.fl, e.ph} = 5'b11000;
            end
            m_stall += 32'(stall);
            m_flush += 32'(flush);
        end
        sb_q.push_back(e);
    endtask

    // Monitor: every falling edge the DUT presents a response for the cycle driven before it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.tag, ".pcwrite"},      32'(pcwrite),      32'(e.pw));
                chk({e.tag, ".ifidwrite"},    32'(ifidwrite),    32'(e.iw));
                chk({e.tag, ".clearcontrol"}, 32'(clearcontrol), 32'(e.cc));
                chk({e.tag, ".ifidflush"},    32'(ifidflush),    32'(e.fl));
                chk({e.tag, ".pipe_hold"},    32'(pipe_hold),    32'(e.ph));
`ifdef HAZARD_PERF_EN
                chk({e.tag, ".stall_cnt"},    stall_cnt,         e.sc);
                chk({e.tag, ".flush_cnt"},    flush_cnt,         e.fc);
`endif
                $display("txn %-10s pw=%0b iw=%0b cc=%0b fl=%0b ph=%0b", e.tag,
                         pcwrite, ifidwrite, clearcontrol, ifidflush, pipe_hold);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    initial begin
        bit   br, busy;
        logic [6:0] op;
        logic [6:0] ops [8];
        ops = '{OP_REG, OP_LUI, OP_LD, OP_BR, OP_JAL, 7'b0010011, 7'b0100011, 7'b1100111};

        step("reset",   0, OP_REG, 5, 5, 1, 5, 0, 0);
        step("reset",   0, OP_REG, 0, 0, 0, 0, 1, 1);
        step("run",     1, OP_REG, 1, 2, 0, 0, 0, 0);
        // Load-use on rs2, then the bubble clears.
        step("lu_rs2",  1, OP_REG, 1, 5, 1, 5, 0, 0);
        step("lu_next", 1, OP_REG, 1, 5, 0, 5, 0, 0);
        step("lu_rd0",  1, OP_REG, 0, 0, 1, 0, 0, 0);
        step("lu_lui",  1, OP_LUI, 5, 1, 1, 5, 0, 0);
        step("lu_rs1",  1, OP_LD,  5, 9, 1, 5, 0, 0);
        step("br_lu",   1, OP_REG, 1, 5, 1, 5, 1, 0);
        step("run",     1, OP_REG, 1, 5, 0, 5, 0, 0);
        // Freeze for three cycles with a branch arriving mid-freeze.
        step("busy1",   1, OP_REG, 1, 2, 0, 0, 0, 1);
        step("busy2",   1, OP_REG, 1, 2, 0, 0, 1, 1);
        step("busy3",   1, OP_REG, 1, 2, 0, 0, 0, 1);
        step("rel_fl",  1, OP_REG, 1, 5, 1, 5, 0, 0);
        step("normal",  1, OP_REG, 1, 2, 0, 0, 0, 0);
        // Reset asserted during a freeze.
        step("busy",    1, OP_REG, 1, 2, 0, 0, 0, 1);
        step("busy",    1, OP_REG, 1, 2, 0, 0, 1, 1);
        step("rst_hold",0, OP_REG, 1, 2, 0, 0, 0, 1);
        step("post_rst",1, OP_REG, 1, 2, 0, 0, 0, 0);
        step("post_rst",1, OP_REG, 1, 2, 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
        step("perf_rst",0, OP_REG, 0, 0, 0, 0, 0, 0);
        step("p_lu",    1, OP_REG, 5, 1, 1, 5, 0, 0);
        step("p_busy",  1, OP_REG, 1, 2, 0, 0, 0, 1);
        step("p_busy",  1, OP_REG, 1, 2, 0, 0, 0, 1);
        step("p_busy",  1, OP_REG, 1, 2, 0, 0, 0, 1);
        step("p_flush", 1, OP_REG, 1, 2, 0, 0, 1, 0);
        step("p_cnt",   1, OP_REG, 1, 2, 0, 0, 0, 0);
        step("p_wrap",  1, OP_REG, 5, 1, 1, 5, 0, 0, 1);
        step("p_wrapd", 1, OP_REG, 1, 2, 0, 0, 0, 0);
`endif
        for (int i = 0; i < 1500; i++) begin
            op   = ops[$urandom_range(0, 7)];
            busy = ($urandom_range(0, 3) == 0);
            br   = !owe_flush && ($urandom_range(0, 5) == 0);
            step("rand", ($urandom_range(0, 99) != 0), op,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), br, busy);
        end
        repeat (2) @(negedge clk);
        #1;
        chk("drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
